// File: rtl/nios2_mem_pattern_master.sv
// Avalon-MM pattern master: fills a word window with seed+i, reads it back and
// compares, reporting pass/fail, a saturating error count and the first failure.
module nios2_mem_pattern_master #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     count,
    input  logic [DATA_W-1:0]   seed,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last cycle in which readdatavalid is still accepted as data
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdWait,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic                check_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [DATA_W-1:0]   seed_q;
    logic [ADDR_W:0]     idx_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic                aborted_q;
    logic                busy_q, done_q, pass_q, timeout_q;
    logic [15:0]         err_count_q;
    logic [ADDR_W-1:0]   first_err_addr_q;
    logic [DATA_W-1:0]   first_err_data_q;

    logic                start_acc, idx_clr, idx_inc, tcnt_clr, tcnt_inc;
    logic                rd_check, set_to, set_abort, fin;
    logic                last;
    logic [DATA_W-1:0]   pattern;

    assign last    = ((idx_q + (ADDR_W+1)'(1)) == count_q);
    assign pattern = seed_q + DATA_W'(idx_q);

    assign avm_address    = base_q + idx_q[ADDR_W-1:0];
    assign avm_writedata  = pattern;
    assign avm_write      = (state_q == StWr);
    assign avm_read       = (state_q == StRdReq);
    assign avm_chipselect = avm_write | avm_read;
    assign avm_byteenable = '1;

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
        rd_check  = 1'b0;
        set_to    = 1'b0;
        set_abort = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_clr   = 1'b1;
                    if (count == '0 || mode == 2'b00) begin
                        state_d = StFin;
                    end else if (mode[0]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StWr: begin
                // Bus held stable while stalled; abort only looked at once accepted
                if (!avm_waitrequest) begin
                    if (abort) begin
                        set_abort = 1'b1;
                        state_d   = StFin;
                    end else if (last) begin
                        idx_clr = 1'b1;
                        state_d = check_q ? StRdReq : StFin;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            StRdReq: begin
                if (!avm_waitrequest) begin
                    tcnt_clr  = 1'b1;
                    set_abort = abort;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (avm_readdatavalid) begin
                    rd_check  = 1'b1;
                    set_abort = abort;
                    if (abort || aborted_q || last) begin
                        state_d = StFin;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = StRdReq;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    set_to  = 1'b1;
                    state_d = StFin;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            StFin: begin
                fin     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Job parameters, index/timeout counters and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            check_q          <= 1'b0;
            base_q           <= '0;
            count_q          <= '0;
            seed_q           <= '0;
            idx_q            <= '0;
            tcnt_q           <= '0;
            aborted_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            done_q <= fin;
            if (start_acc) begin
                check_q          <= mode[1];
                base_q           <= base;
                count_q          <= count;
                seed_q           <= seed;
                aborted_q        <= 1'b0;
                busy_q           <= 1'b1;
                pass_q           <= 1'b0;
                timeout_q        <= 1'b0;
                err_count_q      <= '0;
                first_err_addr_q <= '0;
                first_err_data_q <= '0;
            end
            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + (ADDR_W+1)'(1);
            end
            if (tcnt_clr) begin
                tcnt_q <= '0;
            end else if (tcnt_inc) begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end
            if (set_abort) begin
                aborted_q <= 1'b1;
            end
            if (set_to) begin
                timeout_q <= 1'b1;
            end
            if (rd_check && (avm_readdata != pattern)) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
                if (err_count_q == 16'd0) begin
                    first_err_addr_q <= avm_address;
                    first_err_data_q <= avm_readdata;
                end
            end
            if (fin) begin
                busy_q <= 1'b0;
                pass_q <= (err_count_q == 16'd0) & ~timeout_q & ~aborted_q;
            end
        end
    end

endmodule

// File: tb/tb_nios2_mem_pattern_master.sv
// Self-checking bench: behavioural Avalon slave with random stalls and read
// latency, plus a reference model of the expected bus traffic and results.
module tb_nios2_mem_pattern_master;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   count = '0;
    logic [DW-1:0] seed = '0;
    logic          abort = 1'b0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
    logic [AW-1:0] avm_address;
    logic [DW/8-1:0] avm_byteenable;
    logic          avm_chipselect, avm_write, avm_read;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_waitrequest = 1'b0;
    logic          avm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    nios2_mem_pattern_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base(base),
        .count(count), .seed(seed), .abort(abort), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem [MEMSZ];
    logic [DW-1:0] ref_mem [MEMSZ];

    // Slave knobs
    int wait_pct = 0;
    bit force_wait = 0;
    bit no_resp = 0;
    bit spurious = 0;
    int fixed_delay = -1;

    // Slave state and logs
    bit            rd_pend = 0;
    int            rd_dly = 0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            rd_acc_cyc = 0;
    int            stall_viol = 0;
    int            cs_viol = 0;
    bit            prev_stall = 0;
    logic          prev_wr = 0, prev_rd = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    // Behavioural slave: decides each cycle's handshake at the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            rd_pend = 0;
            avm_readdatavalid = 0;
            avm_waitrequest = 0;
            prev_stall = 0;
        end else begin
            if (avm_chipselect !== (avm_write | avm_read)) cs_viol++;
            if (prev_stall && (avm_write !== prev_wr || avm_read !== prev_rd ||
                               avm_address !== prev_addr ||
                               (prev_wr && avm_writedata !== prev_wdata)))
                stall_viol++;
            avm_readdatavalid = 0;
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    avm_readdatavalid = 1;
                    avm_readdata = mem[rd_addr];
                    rd_pend = 0;
                end else begin
                    rd_dly--;
                end
            end else if (spurious && $urandom_range(99) < 30) begin
                avm_readdatavalid = 1;
                avm_readdata = $urandom;
            end
            avm_waitrequest = force_wait || ($urandom_range(99) < wait_pct);
            prev_stall = (avm_write || avm_read) && avm_waitrequest;
            prev_wr = avm_write;
            prev_rd = avm_read;
            prev_addr = avm_address;
            prev_wdata = avm_writedata;
            if (avm_write && !avm_waitrequest) begin
                mem[avm_address] = avm_writedata;
                wr_addr_q.push_back(avm_address);
                wr_data_q.push_back(avm_writedata);
                wr_cyc_q.push_back(cyc);
            end
            if (avm_read && !avm_waitrequest) begin
                rd_addr_q.push_back(avm_address);
                rd_acc_cyc = cyc;
                if (!no_resp) begin
                    rd_pend = 1;
                    rd_dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(2));
                    rd_addr = avm_address;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        stall_viol = 0;
        cs_viol = 0;
    endtask

    // Pulse start with the given job, then wait (bounded) for done
    task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] n,
                       input logic [DW-1:0] s, output bit got_done, output int done_cyc);
        clear_logs();
        mode = m; base = b; count = n; seed = s; start = 1;
        tick();
        start = 0;
        got_done = 0;
        done_cyc = 0;
        for (int k = 0; k < 20000 && !got_done; k++) begin
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end else begin
                tick();
            end
        end
    endtask

    // Run a job and compare everything against the reference model
    task automatic run_and_check(input string name, input logic [1:0] m,
                                 input logic [AW-1:0] b, input logic [AW:0] n,
                                 input logic [DW-1:0] s);
        int exp_err, exp_wr, exp_rd, dc;
        logic [AW-1:0] exp_fa, a;
        logic [DW-1:0] exp_fd;
        bit got, bad_wr, bad_rd;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = mem[i];
        exp_err = 0; exp_fa = '0; exp_fd = '0;
        exp_wr = (n != 0 && m[0]) ? int'(n) : 0;
        exp_rd = (n != 0 && m[1]) ? int'(n) : 0;
        for (int i = 0; i < exp_wr; i++) ref_mem[AW'(int'(b) + i)] = s + DW'(i);
        for (int i = 0; i < exp_rd; i++) begin
            a = AW'(int'(b) + i);
            if (ref_mem[a] !== s + DW'(i)) begin
                if (exp_err == 0) begin
                    exp_fa = a;
                    exp_fd = ref_mem[a];
                end
                exp_err++;
            end
        end
        run(m, b, n, s, got, dc);
        checks++;
        if (!got) begin errors++; $display("FAIL %s done: never seen, required 1", name); end
        checks++;
        if (pass !== (exp_err == 0)) begin
            errors++; $display("FAIL %s pass: got %0b required %0b", name, pass, exp_err == 0);
        end
        checks++;
        if (err_count !== 16'(exp_err)) begin
            errors++; $display("FAIL %s err_count: got %0d required %0d", name, err_count, exp_err);
        end
        checks++;
        if (first_err_addr !== exp_fa || first_err_data !== exp_fd) begin
            errors++;
            $display("FAIL %s first_err: got %0h/%0h required %0h/%0h", name, first_err_addr,
                     first_err_data, exp_fa, exp_fd);
        end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: got 1 required 0", name); end
        bad_wr = (wr_addr_q.size() != exp_wr);
        for (int i = 0; i < exp_wr && !bad_wr; i++)
            if (wr_addr_q[i] !== AW'(int'(b) + i) || wr_data_q[i] !== s + DW'(i)) bad_wr = 1;
        checks++;
        if (bad_wr) begin
            errors++; $display("FAIL %s writes: got %0d writes required %0d of seed+i", name,
                               wr_addr_q.size(), exp_wr);
        end
        bad_rd = (rd_addr_q.size() != exp_rd);
        for (int i = 0; i < exp_rd && !bad_rd; i++)
            if (rd_addr_q[i] !== AW'(int'(b) + i)) bad_rd = 1;
        checks++;
        if (bad_rd) begin
            errors++; $display("FAIL %s reads: got %0d reads required %0d in order", name,
                               rd_addr_q.size(), exp_rd);
        end
        checks++;
        if (stall_viol != 0 || cs_viol != 0) begin
            errors++; $display("FAIL %s bus: got %0d stall/%0d cs violations required 0", name,
                               stall_viol, cs_viol);
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({busy, done, pass, timeout, err_count, first_err_addr, first_err_data, avm_address,
             avm_chipselect, avm_write, avm_read, avm_writedata} !== '0 ||
            avm_byteenable !== '1) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b pass=%b to=%b err=%0h fa=%0h fd=%0h adr=%0h cs=%b wr=%b rd=%b wd=%0h be=%0h required all 0, be all 1",
                     name, busy, done, pass, timeout, err_count, first_err_addr, first_err_data,
                     avm_address, avm_chipselect, avm_write, avm_read, avm_writedata,
                     avm_byteenable);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_outputs("reset_values");
        tick();
        reset_n = 1;
        tick();
        check_reset_outputs("after_release");
    endtask

    task automatic test_full_fill_check();
        wait_pct = 0;
        run_and_check("full_fill_check", 2'b11, '0, 11'd1024, 32'h1000);
        checks++;
        if (wr_cyc_q.size() != 1024 || wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] != 1023) begin
            errors++; $display("FAIL full_back_to_back: got %0d writes not on consecutive cycles, required 1024 consecutive",
                               wr_cyc_q.size());
        end
        checks++;
        if (mem[5] !== 32'h1005) begin
            errors++; $display("FAIL full_mem5: got %0h required 1005", mem[5]);
        end
    endtask

    task automatic test_wrap();
        run_and_check("wrap", 2'b01, 10'h3FE, 11'd4, 32'hCAFE0000);
    endtask

    task automatic test_stalls();
        wait_pct = 50;
        mem[10'h1F] = 32'd1;
        mem[10'h20] = 32'd0;
        mem[10'h21] = 32'd3;
        run_and_check("stall_check", 2'b10, 10'h1F, 11'd3, 32'd1);
        wait_pct = 0;
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [AW-1:0] b;
        logic [AW:0] n;
        logic [DW-1:0] s;
        wait_pct = 40;
        spurious = 1;
        for (int t = 0; t < 8; t++) begin
            m = 2'($urandom_range(1, 3));
            b = AW'($urandom);
            n = (AW+1)'($urandom_range(1, 40));
            s = $urandom;
            for (int i = 0; i < int'(n); i++)
                mem[AW'(int'(b) + i)] = ($urandom_range(3) == 0) ? $urandom : s + DW'(i);
            run_and_check($sformatf("random%0d", t), m, b, n, s);
        end
        spurious = 0;
        wait_pct = 0;
    endtask

    task automatic test_timeout();
        bit got;
        int dc;
        no_resp = 1;
        run(2'b10, 10'h10, 11'd3, 32'h55, got, dc);
        // done rises TO+1 edges after the accepting edge
        checks++;
        if (!got || dc - rd_acc_cyc != TO + 2) begin
            errors++; $display("FAIL timeout_latency: got %0d required %0d (done seen %0b)",
                               dc - rd_acc_cyc, TO + 2, got);
        end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || rd_addr_q.size() != 1) begin
            errors++; $display("FAIL timeout_flags: got to=%b pass=%b reads=%0d required 1/0/1",
                               timeout, pass, rd_addr_q.size());
        end
        tick();
        no_resp = 0;
        // Data in the last allowed wait cycle is accepted
        mem[10'h40] = 32'h77;
        fixed_delay = TO - 1;
        run(2'b10, 10'h40, 11'd1, 32'h77, got, dc);
        checks++;
        if (!got || timeout !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("FAIL timeout_edge_data: got done=%b to=%b pass=%b required 1/0/1",
                               got, timeout, pass);
        end
        tick();
        fixed_delay = TO;
        run(2'b10, 10'h40, 11'd1, 32'h77, got, dc);
        checks++;
        if (!got || timeout !== 1'b1 || pass !== 1'b0) begin
            errors++; $display("FAIL timeout_edge_late: got done=%b to=%b pass=%b required 1/1/0",
                               got, timeout, pass);
        end
        fixed_delay = -1;
        // Leave time for the late response to drain
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_abort();
        bit got;
        logic [DW-1:0] s;
        s = $urandom;
        clear_logs();
        force_wait = 1;
        mode = 2'b01; base = 10'h50; count = 11'd10; seed = s; start = 1;
        tick();
        start = 0;
        tick(); tick();
        abort = 1;
        tick(); tick();
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 10'h50) begin
            errors++; $display("FAIL abort_hold: got write=%b addr=%0h required 1/50",
                               avm_write, avm_address);
        end
        force_wait = 0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (done) got = 1; else tick();
        end
        abort = 0;
        checks++;
        if (!got || pass !== 1'b0 || err_count !== 16'd0 || timeout !== 1'b0) begin
            errors++; $display("FAIL abort_result: got done=%b pass=%b err=%0d to=%b required 1/0/0/0",
                               got, pass, err_count, timeout);
        end
        checks++;
        if (wr_addr_q.size() != 1 || wr_data_q[0] !== s || stall_viol != 0) begin
            errors++; $display("FAIL abort_writes: got %0d writes, %0d stall violations required 1/0",
                               wr_addr_q.size(), stall_viol);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_logs();
        fixed_delay = 3;
        mem[10'h100] = 32'hDEAD;
        mem[10'h101] = 32'h11;
        mem[10'h102] = 32'h12;
        mode = 2'b10; base = 10'h100; count = 11'd3; seed = 32'h10; start = 1;
        tick();
        start = 0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (rd_addr_q.size() >= 2) seen = 1; else tick();
        end
        tick(); tick();
        checks++;
        if (!seen || busy !== 1'b1 || err_count !== 16'd1) begin
            errors++; $display("FAIL reset_mid_pre: got seen=%b busy=%b err=%0d required 1/1/1",
                               seen, busy, err_count);
        end
        #2 reset_n = 0;
        #1 check_reset_outputs("reset_mid");
        tick(); tick();
        reset_n = 1;
        fixed_delay = -1;
        tick();
        check_reset_outputs("reset_mid_idle");
    endtask

    task automatic test_zero_count();
        clear_logs();
        mode = 2'b11; base = 10'h123; count = '0; seed = 32'h9; start = 1;
        tick();
        start = 0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got busy=%b done=%b required 1/0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b pass=%b required 1/0/1",
                               done, busy, pass);
        end
        tick();
        checks++;
        if (done !== 1'b0 || wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
            errors++; $display("FAIL zero_quiet: got done=%b wr=%0d rd=%0d required 0/0/0",
                               done, wr_addr_q.size(), rd_addr_q.size());
        end
        run_and_check("mode00", 2'b00, 10'h10, 11'd5, 32'h1);
    endtask

    task automatic test_start_while_busy();
        bit got, bad, extra;
        logic [DW-1:0] s;
        s = $urandom;
        clear_logs();
        wait_pct = 30;
        mode = 2'b01; base = 10'h200; count = 11'd8; seed = s; start = 1;
        tick();
        start = 0;
        tick(); tick();
        mode = 2'b11; base = 10'h000; count = 11'd1; seed = ~s; start = 1;
        tick();
        start = 0;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (done) got = 1; else tick();
        end
        bad = (wr_addr_q.size() != 8);
        for (int i = 0; i < 8 && !bad; i++)
            if (wr_addr_q[i] !== AW'(10'h200 + i) || wr_data_q[i] !== s + DW'(i)) bad = 1;
        checks++;
        if (!got || bad || pass !== 1'b1) begin
            errors++; $display("FAIL busy_start: got done=%b writes=%0d pass=%b required first job only",
                               got, wr_addr_q.size(), pass);
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) extra = 1;
        end
        checks++;
        if (extra || rd_addr_q.size() != 0) begin
            errors++; $display("FAIL busy_start_after: got extra activity=%b reads=%0d required 0/0",
                               extra, rd_addr_q.size());
        end
        wait_pct = 0;
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
        test_reset();
        test_full_fill_check();
        test_wrap();
        test_stalls();
        test_random();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_zero_count();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
